// File: rtl/lcd_frame_writer.sv
// LCD pixel-stream receiver: raster tracking, BGP palette mapping and framebuffer writes.
// Build option FB_DOUBLE_BUFFER_EN enables bank swapping on each good frame.
module lcd_frame_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    input  logic [7:0]  bgp,
    input  logic        err_clr,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [1:0]  fb_wdata,
    output logic        fb_bank,
    output logic        disp_bank,
    output logic        frame_done,
    output logic        frame_drop,
    output logic        err_line,
    output logic        err_frame
);

    // state    | meaning
    // S_SYNC   | waiting for the first vsync fall after reset
    // S_LINE   | active line, pixels are written
    // S_HBLANK | horizontal blank, pixels are illegal
    // S_VBLANK | vertical blank, pixels are ignored
    typedef enum logic [1:0] {S_SYNC, S_LINE, S_HBLANK, S_VBLANK} state_t;

    localparam logic [7:0]  H_MAX  = 8'(H_PIXELS);
    localparam logic [7:0]  V_MAX  = 8'(V_LINES);
    localparam logic [8:0]  V_CNT  = 9'(V_LINES);
    localparam logic [14:0] H_STEP = 15'(H_PIXELS);

    state_t      state_q;
    logic        hs_q, vs_q;
    logic [7:0]  x_q, y_q;
    logic [14:0] row_base_q;
    logic        line_bad_q;
    logic        fb_we_q;
    logic [14:0] fb_addr_q;
    logic [1:0]  fb_wdata_q;
    logic        frame_done_q, frame_drop_q;
    logic        err_line_q, err_frame_q;

    logic        hs_rise, hs_fall, vs_rise, vs_fall;
    logic        pix_ok, y_vis;
    logic [7:0]  x_next;
    logic [1:0]  shade;
    logic [8:0]  lines_done;
    logic        frame_end, frame_bad_line, count_ok, frame_good;
    logic        set_err_line, set_err_frame;

    assign hs_rise = lcd_hsync & ~hs_q;
    assign hs_fall = ~lcd_hsync & hs_q;
    assign vs_rise = lcd_vsync & ~vs_q;
    assign vs_fall = ~lcd_vsync & vs_q;

    assign pix_ok = (x_q < H_MAX);
    assign y_vis  = (y_q < V_MAX);
    assign x_next = (lcd_pixel && pix_ok) ? x_q + 8'd1 : x_q;
    assign shade  = bgp[{lcd_color, 1'b0} +: 2];

    // A vsync rise during HBLANK closes a line whose hs_fall never came.
    assign lines_done     = (state_q == S_HBLANK) ? {1'b0, y_q} + 9'd1 : {1'b0, y_q};
    assign frame_end      = vs_rise && (state_q == S_LINE || state_q == S_HBLANK);
    assign frame_bad_line = line_bad_q | ((state_q == S_LINE) && (x_q != 8'd0));
    assign count_ok       = (lines_done == V_CNT);
    assign frame_good     = count_ok & ~frame_bad_line;
    assign set_err_line   = frame_end & frame_bad_line;
    assign set_err_frame  = frame_end & ~count_ok;

`ifdef FB_DOUBLE_BUFFER_EN
    logic fb_bank_q, disp_bank_q;
    assign fb_bank   = fb_bank_q;
    assign disp_bank = disp_bank_q;
`else
    assign fb_bank   = 1'b0;
    assign disp_bank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_SYNC;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            row_base_q   <= 15'd0;
            line_bad_q   <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= 15'd0;
            fb_wdata_q   <= 2'd0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
            fb_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b0;
`endif
        end else begin
            hs_q         <= lcd_hsync;
            vs_q         <= lcd_vsync;
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
            err_line_q   <= set_err_line  | (err_line_q  & ~err_clr);
            err_frame_q  <= set_err_frame | (err_frame_q & ~err_clr);

            if (frame_end) begin
                state_q      <= S_VBLANK;
                frame_done_q <= frame_good;
                frame_drop_q <= ~frame_good;
`ifdef FB_DOUBLE_BUFFER_EN
                if (frame_good) begin
                    disp_bank_q <= fb_bank_q;
                    fb_bank_q   <= ~fb_bank_q;
                end
`endif
            end else begin
                case (state_q)
                    S_SYNC, S_VBLANK: begin
                        if (vs_fall) begin
                            state_q    <= S_LINE;
                            x_q        <= 8'd0;
                            y_q        <= 8'd0;
                            row_base_q <= 15'd0;
                            line_bad_q <= 1'b0;
                        end
                    end
                    S_LINE: begin
                        if (lcd_pixel) begin
                            if (pix_ok) begin
                                x_q <= x_next;
                                if (y_vis) begin
                                    fb_we_q    <= 1'b1;
                                    fb_addr_q  <= row_base_q + {7'd0, x_q};
                                    fb_wdata_q <= shade;
                                end
                            end else begin
                                line_bad_q <= 1'b1;
                            end
                        end
                        if (hs_rise) begin
                            state_q <= S_HBLANK;
                            if (x_next != H_MAX) line_bad_q <= 1'b1;
                        end
                    end
                    S_HBLANK: begin
                        if (lcd_pixel) line_bad_q <= 1'b1;
                        if (hs_fall) begin
                            state_q <= S_LINE;
                            x_q     <= 8'd0;
                            if (y_q != 8'hFF) y_q <= y_q + 8'd1;
                            if (y_q >= V_MAX) line_bad_q <= 1'b1;
                            if (y_vis) row_base_q <= row_base_q + H_STEP;
                        end
                    end
                    default: state_q <= S_SYNC;
                endcase
            end
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign frame_done = frame_done_q;
    assign frame_drop = frame_drop_q;
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomised bench for lcd_frame_writer: a frame-level reference model predicts writes,
// frame outcomes, banks and sticky errors.
module tb_lcd_frame_writer;

    localparam int H = 160;
    localparam int V = 144;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_hsync = 1'b0, lcd_vsync = 1'b0, lcd_pixel = 1'b0, err_clr = 1'b0;
    logic [1:0]  lcd_color = 2'd0;
    logic [7:0]  bgp = 8'd0;
    logic        fb_we, fb_bank, disp_bank, frame_done, frame_drop, err_line, err_frame;
    logic [14:0] fb_addr;
    logic [1:0]  fb_wdata;

    lcd_frame_writer #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk(clk), .rst(rst),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
        .lcd_pixel(lcd_pixel), .lcd_color(lcd_color), .bgp(bgp), .err_clr(err_clr),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_bank(fb_bank), .disp_bank(disp_bank),
        .frame_done(frame_done), .frame_drop(frame_drop),
        .err_line(err_line), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit          active = 1'b0;
    int          frame_lines = 0;
    int          cur_x = 0;
    bit          bad_len = 1'b0;
    int          exp_done = 0, exp_drop = 0;
    bit          m_fb_bank = 1'b0, m_disp_bank = 1'b0;
    bit          m_err_line = 1'b0, m_err_frame = 1'b0;
    logic [16:0] exp_q[$];

    int          wr_cnt = 0, done_cnt = 0, drop_cnt = 0;
    logic [14:0] last_addr = 15'd0;

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            wr_cnt++;
            last_addr = fb_addr;
            if (exp_q.size() == 0)
                check_eq("wr_unexpected", 32'(fb_we), 32'd0);
            else
                check_eq("wr_addr_data", 32'({fb_addr, fb_wdata}), 32'(exp_q.pop_front()));
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_drop === 1'b1) drop_cnt++;
    end

    task automatic px(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        lcd_pixel = 1'b1;
        lcd_color = c;
        bgp       = p;
        if (active) begin
            if (frame_lines < V && cur_x < H)
                exp_q.push_back({15'(frame_lines * H + cur_x), 2'((p >> (2 * c)) & 8'd3)});
            cur_x++;
        end
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++)
            px(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
        @(negedge clk);
        lcd_pixel = 1'b0;
    endtask

    task automatic hs_up();
        @(negedge clk);
        lcd_hsync = 1'b1;
        if (active) begin
            if (cur_x != H) bad_len = 1'b1;
            frame_lines++;
            cur_x = 0;
        end
    endtask

    task automatic hs_pulse();
        hs_up();
        repeat (3) @(negedge clk);
        lcd_hsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        lcd_vsync = 1'b1;
        repeat (2) @(negedge clk);
        lcd_vsync   = 1'b0;
        active      = 1'b1;
        frame_lines = 0;
        cur_x       = 0;
        bad_len     = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_frame();
        bit good;
        good = (frame_lines == V) && !bad_len;
        @(negedge clk);
        lcd_vsync = 1'b1;
        m_err_line  = m_err_line  | bad_len | (frame_lines > V);
        m_err_frame = m_err_frame | (frame_lines != V);
        if (good) exp_done++;
        else exp_drop++;
`ifdef FB_DOUBLE_BUFFER_EN
        if (good) begin
            m_disp_bank = m_fb_bank;
            m_fb_bank   = ~m_fb_bank;
        end
`endif
        active = 1'b0;
        @(negedge clk);
        check_eq("frame_done_pulse", 32'(frame_done), 32'(good));
        check_eq("frame_drop_pulse", 32'(frame_drop), 32'(!good));
        check_eq("fb_bank", 32'(fb_bank), 32'(m_fb_bank));
        check_eq("disp_bank", 32'(disp_bank), 32'(m_disp_bank));
        rand_pixels(3);
        lcd_hsync = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("done_count", 32'(done_cnt), 32'(exp_done));
        check_eq("drop_count", 32'(drop_cnt), 32'(exp_drop));
        check_eq("err_line", 32'(err_line), 32'(m_err_line));
        check_eq("err_frame", 32'(err_frame), 32'(m_err_frame));
    endtask

    task automatic clear_errors();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err_line  = 1'b0;
        m_err_frame = 1'b0;
        check_eq("err_line_clr", 32'(err_line), 32'(m_err_line));
        check_eq("err_frame_clr", 32'(err_frame), 32'(m_err_frame));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 32'({fb_we, fb_addr, fb_wdata, fb_bank, disp_bank, frame_done, frame_drop, err_line, err_frame}),
                 32'd0);
        rst = 1'b1;

        // Reset released mid-line: nothing may be written before a vsync fall.
        rand_pixels(20);
        hs_pulse();
        rand_pixels(30);
        check_eq("sync_no_writes", 32'(wr_cnt), 32'd0);

        // Nominal full frame
        start_frame();
        for (int l = 0; l < V; l++) begin
            rand_pixels(H);
            hs_pulse();
        end
        check_eq("nominal_write_count", 32'(wr_cnt), 32'd23040);
        check_eq("nominal_last_addr", 32'(last_addr), 32'd23039);
        end_frame();

        // Palette: one short line with both reference palettes
        start_frame();
        for (int c = 0; c < 4; c++) px(2'(c), 8'hE4);
        for (int c = 0; c < 4; c++) px(2'(c), 8'h1B);
        @(negedge clk);
        lcd_pixel = 1'b0;
        hs_pulse();
        end_frame();
        clear_errors();

        // Short line 5
        start_frame();
        for (int l = 0; l < 8; l++) begin
            rand_pixels((l == 5) ? H - 1 : H);
            hs_pulse();
        end
        end_frame();
        clear_errors();

        // Overrun on line 0
        start_frame();
        rand_pixels(H + 2);
        hs_pulse();
        rand_pixels(H);
        hs_pulse();
        end_frame();

        // Full frame whose vsync rises during the last HBLANK; errors stay sticky
        start_frame();
        for (int l = 0; l < V - 1; l++) begin
            rand_pixels(H);
            hs_pulse();
        end
        rand_pixels(H);
        hs_up();
        @(negedge clk);
        end_frame();

        // Reset in the middle of line 70
        start_frame();
        for (int l = 0; l < 70; l++) begin
            rand_pixels(H);
            hs_pulse();
        end
        rand_pixels(30);
        rst = 1'b0;
        active = 1'b0;
        m_fb_bank = 1'b0;
        m_disp_bank = 1'b0;
        m_err_line = 1'b0;
        m_err_frame = 1'b0;
        @(negedge clk);
        check_eq("midreset_outputs",
                 32'({fb_we, fb_addr, fb_wdata, fb_bank, disp_bank, frame_done, frame_drop, err_line, err_frame}),
                 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rand_pixels(10);
        check_eq("midreset_no_writes_before_sync", 32'(exp_q.size()), 32'd0);

        start_frame();
        px(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
        @(negedge clk);
        lcd_pixel = 1'b0;
        check_eq("restart_first_we", 32'(fb_we), 32'd1);
        check_eq("restart_first_addr", 32'(fb_addr), 32'd0);
        rand_pixels(H - 1);
        hs_pulse();
        repeat (2) @(negedge clk);
        check_eq("done_count_final", 32'(done_cnt), 32'(exp_done));
        check_eq("writes_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
